// File: rtl/tmr_count_ctrl_if.sv
// Channel-side bundle for the count-source / clear-control stage.
// The slave is the tmr_count_ctrl block. The master is whatever drives it:
// the timer register file, the comparators, the paired channel and the pins.
interface tmr_count_ctrl_if;
  logic [2:0] cks;         // clock select
  logic [1:0] cclr;        // clear select
  logic       tmci;        // external count clock (asynchronous)
  logic       tmri;        // external counter reset (asynchronous)
  logic       cascade_in;  // one-cycle event from the paired channel
  logic       cma;         // compare match A level
  logic       cmb;         // compare match B level
  logic       count_en;    // TCNT increments on this cycle
  logic       count_clr;   // TCNT loads 0 on this cycle

  modport master (
    output cks, cclr, tmci, tmri, cascade_in, cma, cmb,
    input  count_en, count_clr
  );

  modport slave (
    input  cks, cclr, tmci, tmri, cascade_in, cma, cmb,
    output count_en, count_clr
  );
endinterface

// File: rtl/tmr_count_ctrl.sv
// Count-source and clear-control stage for one 8-bit timer channel.
// It chooses what advances TCNT: a prescaler tap, TMCI edges, or the cascade
// pulse from the paired channel. It also decides when TCNT clears: on a
// compare-match rising edge, or on a TMRI rising edge.
// Both outputs are single-cycle registered pulses.
module tmr_count_ctrl #(
  parameter int PRESCALE_W = 13  // must be >= 13 to supply the /8192 tap
) (
  input  logic            clk,
  input  logic            rst_n,
  tmr_count_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CKS_STOP      = 3'd0,
    CKS_DIV8      = 3'd1,
    CKS_DIV64     = 3'd2,
    CKS_DIV8192   = 3'd3,
    CKS_CASCADE   = 3'd4,
    CKS_TMCI_RISE = 3'd5,
    CKS_TMCI_FALL = 3'd6,
    CKS_TMCI_BOTH = 3'd7
  } cks_e;

  typedef enum logic [1:0] {
    CCLR_NONE    = 2'd0,
    CCLR_MATCH_A = 2'd1,
    CCLR_MATCH_B = 2'd2,
    CCLR_TMRI    = 2'd3
  } cclr_e;

  cks_e  cks_sel;
  cclr_e cclr_sel;

  assign cks_sel  = cks_e'(bus.cks);
  assign cclr_sel = cclr_e'(bus.cclr);

  // Prescaler and its taps
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tick_div8, tick_div64, tick_div8192;

  // TMCI / TMRI synchronisers and history flops
  logic [1:0] tmci_sync_q, tmci_sync_d;
  logic       tmci_hist_q, tmci_hist_d;
  logic [1:0] tmri_sync_q, tmri_sync_d;
  logic       tmri_hist_q, tmri_hist_d;
  logic       tmci_rise, tmci_fall, tmri_rise;

  // Compare-match edge detection
  logic sel_match;
  logic match_q, match_d;

  // Registered outputs
  logic count_en_q, count_en_d;
  logic count_clr_q, count_clr_d;

  // Free-running prescaler. It wraps naturally at all-ones, and cks never
  // touches it. A tap fires when the low log2(N) bits are all ones, which
  // gives one tick every N clocks.
  always_comb begin
    presc_d      = presc_q + 1'b1;
    tick_div8    = &presc_q[2:0];
    tick_div64   = &presc_q[5:0];
    tick_div8192 = &presc_q[12:0];
  end

  // Synchroniser shift and edge extraction. These run in every mode, so a
  // mode switch never sees stale history.
  always_comb begin
    tmci_sync_d = {tmci_sync_q[0], bus.tmci};
    tmci_hist_d = tmci_sync_q[1];
    tmri_sync_d = {tmri_sync_q[0], bus.tmri};
    tmri_hist_d = tmri_sync_q[1];
    tmci_rise   = tmci_sync_q[1] & ~tmci_hist_q;
    tmci_fall   = ~tmci_sync_q[1] & tmci_hist_q;
    tmri_rise   = tmri_sync_q[1] & ~tmri_hist_q;
  end

  // Count-source select. The current cks applies to the tick evaluated in
  // the same cycle, so a switch can neither duplicate a pulse nor merge two.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path through the case infers a latch.
    count_en_d = 1'b0;
    case (cks_sel)
      CKS_STOP:      count_en_d = 1'b0;
      CKS_DIV8:      count_en_d = tick_div8;
      CKS_DIV64:     count_en_d = tick_div64;
      CKS_DIV8192:   count_en_d = tick_div8192;
      CKS_CASCADE:   count_en_d = bus.cascade_in;
      CKS_TMCI_RISE: count_en_d = tmci_rise;
      CKS_TMCI_FALL: count_en_d = tmci_fall;
      CKS_TMCI_BOTH: count_en_d = tmci_rise | tmci_fall;
      default:       count_en_d = 1'b0;
    endcase
  end

  // Clear select. A match level held high clears only once, because only
  // its rising edge (against the registered level) produces a pulse.
  always_comb begin
    sel_match   = 1'b0;
    count_clr_d = 1'b0;
    case (cclr_sel)
      CCLR_MATCH_A: sel_match = bus.cma;
      CCLR_MATCH_B: sel_match = bus.cmb;
      default:      sel_match = 1'b0;
    endcase
    match_d = sel_match;
    case (cclr_sel)
      CCLR_MATCH_A,
      CCLR_MATCH_B: count_clr_d = sel_match & ~match_q;
      CCLR_TMRI:    count_clr_d = tmri_rise;
      default:      count_clr_d = 1'b0;
    endcase
  end

  // Prescaler state
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Synchroniser, history and match-level flops
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: synchroniser and history flops are reset too, so the first edge after release is measured against a known 0.
    if (!rst_n) begin
      tmci_sync_q <= 2'b00;
      tmci_hist_q <= 1'b0;
      tmri_sync_q <= 2'b00;
      tmri_hist_q <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      tmci_sync_q <= tmci_sync_d;
      tmci_hist_q <= tmci_hist_d;
      tmri_sync_q <= tmri_sync_d;
      tmri_hist_q <= tmri_hist_d;
      match_q     <= match_d;
    end
  end

  // Output pulses. Neither pulse suppresses the other. TCNT gives clear
  // priority when both are asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
    end else begin
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
    end
  end

  assign bus.count_en  = count_en_q;
  assign bus.count_clr = count_clr_q;

endmodule

// File: tb/tb_tmr_count_ctrl.sv
// Testbench for tmr_count_ctrl.
// Inputs are recorded per cycle. The reference model then predicts each
// output cycle from arithmetic on the cycle number (prescaler taps) and from
// the recorded input history (edge latencies).
module tb_tmr_count_ctrl;
  localparam int MAXC = 65536;
  typedef int iq_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;  // cycle number; the first edge after reset release is 1

  logic [2:0] s_cks  [MAXC];
  logic [1:0] s_cclr [MAXC];
  bit         s_tmci [MAXC];
  bit         s_tmri [MAXC];
  bit         s_cas  [MAXC];
  bit         s_cma  [MAXC];
  bit         s_cmb  [MAXC];
  bit         o_en   [MAXC];
  bit         o_clr  [MAXC];

  tmr_count_ctrl_if bus ();

  tmr_count_ctrl #(.PRESCALE_W(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Record the inputs seen by each rising edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
    end else if (cyc < MAXC - 1) begin
      cyc              <= cyc + 1;
      s_cks[cyc + 1]   <= bus.cks;
      s_cclr[cyc + 1]  <= bus.cclr;
      s_tmci[cyc + 1]  <= bus.tmci;
      s_tmri[cyc + 1]  <= bus.tmri;
      s_cas[cyc + 1]   <= bus.cascade_in;
      s_cma[cyc + 1]   <= bus.cma;
      s_cmb[cyc + 1]   <= bus.cmb;
    end
  end

  // Record the outputs mid-cycle
  always @(negedge clk) begin
    if (rst_n && cyc > 0) begin
      o_en[cyc]  <= bus.count_en;
      o_clr[cyc] <= bus.count_clr;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit tmv(int k);
    return (k <= 0) ? 1'b0 : s_tmci[k];
  endfunction

  function automatic bit trv(int k);
    return (k <= 0) ? 1'b0 : s_tmri[k];
  endfunction

  function automatic bit selm(int k);
    if (k <= 0) return 1'b0;
    if (s_cclr[k] == 2'd1) return s_cma[k];
    if (s_cclr[k] == 2'd2) return s_cmb[k];
    return 1'b0;
  endfunction

  // Cycle c follows edge c. The prescaler reads c-1 before that edge, so an
  // internal /N pulse lands exactly on cycles with c mod N == 0. A pin
  // change first sampled at edge k produces its pulse in cycle k+2.
  function automatic bit model_en(int c);
    case (s_cks[c])
      3'd0:    return 1'b0;
      3'd1:    return (c % 8) == 0;
      3'd2:    return (c % 64) == 0;
      3'd3:    return (c % 8192) == 0;
      3'd4:    return s_cas[c];
      3'd5:    return tmv(c - 2) && !tmv(c - 3);
      3'd6:    return !tmv(c - 2) && tmv(c - 3);
      default: return tmv(c - 2) != tmv(c - 3);
    endcase
  endfunction

  function automatic bit model_clr(int c);
    case (s_cclr[c])
      2'd1, 2'd2: return selm(c) && !selm(c - 1);
      2'd3:       return trv(c - 2) && !trv(c - 3);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic iq_t pulses(int a, int b, bit clr);
    iq_t q;
    for (int c = a; c <= b; c++) begin
      if (clr ? o_clr[c] : o_en[c]) q.push_back(c);
    end
    return q;
  endfunction

  // First cycle in [a,b] where the observed outputs and the model disagree, else -1
  function automatic int first_diff(int a, int b);
    for (int c = a; c <= b; c++) begin
      if (o_en[c] !== model_en(c) || o_clr[c] !== model_clr(c)) return c;
    end
    return -1;
  endfunction

  task automatic advance(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    iq_t q;
    int  bad;
    int  d;
    rst_n = 1'b0;
    bus.cks = 3'd1; bus.cclr = 2'd0; bus.tmci = 1'b0; bus.tmri = 1'b0;
    bus.cascade_in = 1'b0; bus.cma = 1'b0; bus.cmb = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.count_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_count_en: got %b expected 0", bus.count_en);
    end
    n_tests++;
    if (bus.count_clr !== 1'b0) begin
      n_fail++; $display("FAIL reset_count_clr: got %b expected 0", bus.count_clr);
    end
    rst_n = 1'b1;
    advance(64);
    q = pulses(1, 64, 1'b0);
    n_tests++;
    if (q.size() !== 8) begin
      n_fail++; $display("FAIL div8_pulse_count: got %0d expected 8", q.size());
    end
    n_tests++;
    if ((q.size() > 0 ? q[0] : -1) !== 8) begin
      n_fail++; $display("FAIL div8_first_pulse: got cycle %0d expected 8", q.size() > 0 ? q[0] : -1);
    end
    bad = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != 8) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL div8_spacing: got %0d bad gaps expected 0", bad);
    end
    q = pulses(1, 64, 1'b1);
    n_tests++;
    if (q.size() !== 0) begin
      n_fail++; $display("FAIL div8_no_clear: got %0d clears expected 0", q.size());
    end
    d = first_diff(1, 64);
    n_tests++;
    if (d !== -1) begin
      n_fail++; $display("FAIL model_div8: cycle %0d en=%b clr=%b expected en=%b clr=%b",
                         d, o_en[d], o_clr[d], model_en(d), model_clr(d));
    end
  endtask

  task automatic test_prescale;
    iq_t q;
    int  a, sw, d, dbl;
    a = cyc + 1;
    bus.cks = 3'd3;
    advance(20000);
    q = pulses(a, cyc, 1'b0);
    n_tests++;
    if (q.size() !== 2) begin
      n_fail++; $display("FAIL div8192_count: got %0d expected 2", q.size());
    end
    n_tests++;
    if ((q.size() == 2 ? q[1] - q[0] : -1) !== 8192) begin
      n_fail++; $display("FAIL div8192_spacing: got %0d expected 8192", q.size() == 2 ? q[1] - q[0] : -1);
    end
    advance($urandom_range(1, 100));
    sw = cyc;
    bus.cks = 3'd2;
    advance(200);
    q = pulses(sw + 1, cyc, 1'b0);
    n_tests++;
    if (!(q.size() > 0 && q[0] - sw <= 64)) begin
      n_fail++; $display("FAIL switch_to_div64: got first pulse %0d clk after switch expected <= 64",
                         q.size() > 0 ? q[0] - sw : -1);
    end
    q = pulses(a, cyc, 1'b0);
    dbl = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] == 1) dbl++;
    n_tests++;
    if (dbl !== 0) begin
      n_fail++; $display("FAIL switch_double_pulse: got %0d double pulses expected 0", dbl);
    end
    d = first_diff(a, cyc);
    n_tests++;
    if (d !== -1) begin
      n_fail++; $display("FAIL model_prescale: cycle %0d en=%b clr=%b expected en=%b clr=%b",
                         d, o_en[d], o_clr[d], model_en(d), model_clr(d));
    end
  endtask

  task automatic test_cks_switch;
    int a, d;
    a = cyc + 1;
    repeat (40) begin
      bus.cks = 3'($urandom_range(0, 3));
      advance($urandom_range(1, 40));
    end
    d = first_diff(a, cyc);
    n_tests++;
    if (d !== -1) begin
      n_fail++; $display("FAIL model_cks_switch: cycle %0d en=%b expected %b", d, o_en[d], model_en(d));
    end
  endtask

  task automatic test_tmci;
    iq_t q, tq;
    int  a, d, bad;
    bus.cks = 3'd0; bus.tmci = 1'b0;
    advance(10);
    // An edge that happens while stopped must not show up after entering an edge mode
    bus.tmci = 1'b1;
    advance(10);
    a = cyc + 1;
    bus.cks = 3'd7;
    advance(10);
    q = pulses(a, cyc, 1'b0);
    n_tests++;
    if (q.size() !== 0) begin
      n_fail++; $display("FAIL tmci_stale_history: got %0d pulses expected 0", q.size());
    end
    bus.cks = 3'd0; bus.tmci = 1'b0;
    advance(10);
    // Both edges
    bus.cks = 3'd7;
    a = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      advance(10);
      bus.tmci = ~bus.tmci;
      tq.push_back(cyc);
    end
    advance(10);
    q = pulses(a, cyc, 1'b0);
    n_tests++;
    if (q.size() !== 5) begin
      n_fail++; $display("FAIL tmci_both_count: got %0d expected 5", q.size());
    end
    bad = 0;
    for (int i = 0; i < q.size() && i < 5; i++) if (q[i] != tq[i] + 3) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL tmci_both_latency: got %0d pulses not 3 clk after toggle expected 0", bad);
    end
    // Rising edges only
    bus.cks = 3'd0; bus.tmci = 1'b0;
    advance(10);
    bus.cks = 3'd5;
    a = cyc + 1;
    tq.delete();
    for (int i = 0; i < 5; i++) begin
      advance(10);
      bus.tmci = ~bus.tmci;
      tq.push_back(cyc);
    end
    advance(10);
    q = pulses(a, cyc, 1'b0);
    n_tests++;
    if (q.size() !== 3) begin
      n_fail++; $display("FAIL tmci_rise_count: got %0d expected 3", q.size());
    end
    n_tests++;
    if (q.size() != 3 || q[0] != tq[0] + 3 || q[1] != tq[2] + 3 || q[2] != tq[4] + 3) begin
      n_fail++; $display("FAIL tmci_rise_latency: got first pulse %0d expected %0d",
                         q.size() > 0 ? q[0] : -1, tq[0] + 3);
    end
    // Random pin activity across all three edge modes
    a = cyc + 1;
    repeat (8) begin
      bus.cks = 3'($urandom_range(5, 7));
      repeat (50) begin
        if ($urandom_range(0, 3) == 0) bus.tmci = ~bus.tmci;
        advance(1);
      end
    end
    d = first_diff(a, cyc);
    n_tests++;
    if (d !== -1) begin
      n_fail++; $display("FAIL model_tmci_random: cycle %0d en=%b expected %b", d, o_en[d], model_en(d));
    end
  endtask

  task automatic test_cascade;
    iq_t q;
    int  base, a, d;
    bus.cks = 3'd4; bus.cascade_in = 1'b0;
    base = cyc;
    advance(10);
    bus.cascade_in = 1'b1;  // cycles base+10 and base+11
    advance(2);
    bus.cascade_in = 1'b0;
    advance(18);
    bus.cascade_in = 1'b1;  // cycle base+30
    advance(1);
    bus.cascade_in = 1'b0;
    advance(10);
    q = pulses(base + 1, cyc, 1'b0);
    n_tests++;
    if (q.size() != 3 || q[0] != base + 11 || q[1] != base + 12 || q[2] != base + 31) begin
      n_fail++; $display("FAIL cascade_pulses: got %0d pulses first at +%0d expected 3 at +11,+12,+31",
                         q.size(), q.size() > 0 ? q[0] - base : -1);
    end
    a = cyc + 1;
    repeat (300) begin
      bus.cascade_in = ($urandom_range(0, 2) == 0);
      advance(1);
    end
    bus.cascade_in = 1'b0;
    advance(2);
    d = first_diff(a, cyc);
    n_tests++;
    if (d !== -1) begin
      n_fail++; $display("FAIL model_cascade: cycle %0d en=%b expected %b", d, o_en[d], model_en(d));
    end
  endtask

  task automatic test_clear;
    iq_t q;
    int  a, t, d;
    bus.cks = 3'd0; bus.cclr = 2'd1; bus.cma = 1'b0; bus.cmb = 1'b0; bus.tmri = 1'b0;
    advance(5);
    a = cyc + 1;
    bus.cma = 1'b1;
    t = cyc;
    advance(40);
    bus.cma = 1'b0;
    advance(5);
    q = pulses(a, cyc, 1'b1);
    n_tests++;
    if (q.size() != 1 || q[0] != t + 1) begin
      n_fail++; $display("FAIL clear_match_a: got %0d pulses first at +%0d expected 1 at +1",
                         q.size(), q.size() > 0 ? q[0] - t : -1);
    end
    bus.cclr = 2'd3;
    advance(5);
    a = cyc + 1;
    bus.tmri = 1'b1;
    t = cyc;
    advance(10);
    bus.tmri = 1'b0;
    advance(10);
    q = pulses(a, cyc, 1'b1);
    n_tests++;
    if (q.size() != 1 || q[0] != t + 3) begin
      n_fail++; $display("FAIL clear_tmri: got %0d pulses first at +%0d expected 1 at +3",
                         q.size(), q.size() > 0 ? q[0] - t : -1);
    end
    // Random match B levels, with match A toggling as a distractor
    bus.cclr = 2'd2;
    a = cyc + 1;
    repeat (200) begin
      if ($urandom_range(0, 4) == 0) bus.cmb = ~bus.cmb;
      if ($urandom_range(0, 2) == 0) bus.cma = ~bus.cma;
      advance(1);
    end
    d = first_diff(a, cyc);
    n_tests++;
    if (d !== -1) begin
      n_fail++; $display("FAIL model_clear_b: cycle %0d clr=%b expected %b", d, o_clr[d], model_clr(d));
    end
    // No clear source selected
    bus.cclr = 2'd0;
    advance(2);
    a = cyc + 1;
    repeat (100) begin
      bus.cma  = 1'($urandom_range(0, 1));
      bus.cmb  = 1'($urandom_range(0, 1));
      bus.tmri = 1'($urandom_range(0, 1));
      advance(1);
    end
    q = pulses(a, cyc, 1'b1);
    n_tests++;
    if (q.size() !== 0) begin
      n_fail++; $display("FAIL clear_none: got %0d clears expected 0", q.size());
    end
    bus.cma = 1'b0; bus.cmb = 1'b0; bus.tmri = 1'b0;
    advance(5);
  endtask

  task automatic test_back_to_back;
    int a, t, d;
    bus.cks = 3'd1; bus.cclr = 2'd1; bus.cma = 1'b0;
    advance(1);
    while (cyc % 8 != 7) advance(1);
    bus.cma = 1'b1;  // its clear lands on the same cycle as the next /8 pulse
    t = cyc;
    advance(2);
    bus.cma = 1'b0;
    n_tests++;
    if (o_en[t + 1] !== 1'b1) begin
      n_fail++; $display("FAIL simultaneous_en: got %b expected 1", o_en[t + 1]);
    end
    n_tests++;
    if (o_clr[t + 1] !== 1'b1) begin
      n_fail++; $display("FAIL simultaneous_clr: got %b expected 1", o_clr[t + 1]);
    end
    // Everything random at once
    a = cyc + 1;
    repeat (30) begin
      bus.cks  = 3'($urandom_range(0, 7));
      bus.cclr = 2'($urandom_range(0, 3));
      repeat ($urandom_range(10, 40)) begin
        if ($urandom_range(0, 3) == 0) bus.tmci = ~bus.tmci;
        if ($urandom_range(0, 5) == 0) bus.tmri = ~bus.tmri;
        if ($urandom_range(0, 5) == 0) bus.cma  = ~bus.cma;
        if ($urandom_range(0, 5) == 0) bus.cmb  = ~bus.cmb;
        bus.cascade_in = ($urandom_range(0, 3) == 0);
        advance(1);
      end
    end
    d = first_diff(a, cyc);
    n_tests++;
    if (d !== -1) begin
      n_fail++; $display("FAIL model_random_all: cycle %0d en=%b clr=%b expected en=%b clr=%b",
                         d, o_en[d], o_clr[d], model_en(d), model_clr(d));
    end
    bus.cascade_in = 1'b0;
  endtask

  task automatic test_async_reset;
    iq_t q;
    int  d;
    bus.cks = 3'd7; bus.cclr = 2'd0; bus.cma = 1'b0; bus.cmb = 1'b0; bus.tmri = 1'b0;
    while (cyc % 8192 != 8179) begin
      if ((cyc % 8192) < 8170 && $urandom_range(0, 3) == 0) bus.tmci = ~bus.tmci;
      advance(1);
    end
    bus.tmci = ~bus.tmci;  // its pulse lands while the prescaler reads 0x1FF6
    advance(3);
    n_tests++;
    if (bus.count_en !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_pulse: got %b expected 1", bus.count_en);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.count_en !== 1'b0 || bus.count_clr !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_outputs: got en=%b clr=%b expected 0 0", bus.count_en, bus.count_clr);
    end
    repeat (3) begin
      @(negedge clk);
      bus.tmci = ~bus.tmci;
    end
    bus.tmci = 1'b0; bus.cks = 3'd1;
    rst_n = 1'b1;
    advance(64);
    q = pulses(1, 64, 1'b0);
    n_tests++;
    if (q.size() != 8 || q[0] != 8) begin
      n_fail++; $display("FAIL post_reset_div8: got %0d pulses first at %0d expected 8 first at 8",
                         q.size(), q.size() > 0 ? q[0] : -1);
    end
    d = first_diff(1, 64);
    n_tests++;
    if (d !== -1) begin
      n_fail++; $display("FAIL model_post_reset: cycle %0d en=%b expected %b", d, o_en[d], model_en(d));
    end
  endtask

  initial begin
    bus.cks = 3'd0; bus.cclr = 2'd0; bus.tmci = 1'b0; bus.tmri = 1'b0;
    bus.cascade_in = 1'b0; bus.cma = 1'b0; bus.cmb = 1'b0;
    test_reset();
    test_prescale();
    test_cks_switch();
    test_tmci();
    test_cascade();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
